// File: rtl/matrix_scanner.sv
// Double-buffered row-scan driver for an LED dot matrix: back-buffer writes are
// committed and swapped into the displayed front buffer only at a frame boundary.
module matrix_scanner #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int DWELL        = 1,
    parameter int BLINK_FRAMES = 32,
    localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            ani_clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [COLS-1:0] wr_data,
    output logic            wr_ready,
    input  logic            commit,
    input  logic            blink_en,
    output logic [ROWS-1:0] dot_row,
    output logic [COLS-1:0] dot_col,
    output logic            frame_start
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [RW:0]   ROWS_EXT   = (RW + 1)'(ROWS);

    logic [RW-1:0]   row_idx_q, row_idx_d;
    logic [DW-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic            blink_phase_q, blink_phase_d;
    logic            pending_q, pending_d;
    logic [COLS-1:0] front_q [ROWS];
    logic [COLS-1:0] front_d [ROWS];
    logic [COLS-1:0] back_q  [ROWS];
    logic [COLS-1:0] back_d  [ROWS];
    logic [ROWS-1:0] dot_row_q, dot_row_d;
    logic [COLS-1:0] dot_col_q, dot_col_d;
    logic            frame_start_q, frame_start_d;

    logic row_last;
    logic dwell_last;
    logic wrap;

    always_comb begin
        row_idx_d     = row_idx_q;
        dwell_cnt_d   = dwell_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        pending_d     = pending_q;
        front_d       = front_q;
        back_d        = back_q;

        row_last   = (row_idx_q == ROW_LAST);
        dwell_last = (dwell_cnt_q == DWELL_LAST);
        wrap       = row_last && dwell_last;

        if (dwell_last) begin
            dwell_cnt_d = '0;
            row_idx_d   = row_last ? '0 : row_idx_q + RW'(1);
        end else begin
            dwell_cnt_d = dwell_cnt_q + DW'(1);
        end

        // Writes only land while no swap is outstanding, so the swap below
        // never races a write into the same back row.
        if (wr_en && !pending_q && ({1'b0, wr_row} < ROWS_EXT)) begin
            back_d[wr_row] = wr_data;
        end

        // A commit seen on the wrap edge only arms pending; the swap waits
        // for the next wrap.
        if (wrap && pending_q) begin
            front_d   = back_q;
            pending_d = 1'b0;
        end else if (commit && !pending_q) begin
            pending_d = 1'b1;
        end

        if (wrap) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end

        // Output registers reflect the pre-advance scan position.
        for (int r = 0; r < ROWS; r++) begin
            dot_row_d[r] = (r != (ROWS - 1 - int'(row_idx_q)));
        end
        dot_col_d     = (blink_en && !blink_phase_q) ? '0 : front_q[row_idx_q];
        frame_start_d = (row_idx_q == '0) && (dwell_cnt_q == '0);
    end

    always_ff @(posedge ani_clk or negedge rst_n) begin
        if (!rst_n) begin
            row_idx_q     <= '0;
            dwell_cnt_q   <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            pending_q     <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                front_q[r] <= '0;
                back_q[r]  <= '0;
            end
            dot_row_q     <= '1;
            dot_col_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            row_idx_q     <= row_idx_d;
            dwell_cnt_q   <= dwell_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            pending_q     <= pending_d;
            front_q       <= front_d;
            back_q        <= back_d;
            dot_row_q     <= dot_row_d;
            dot_col_q     <= dot_col_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign dot_row     = dot_row_q;
    assign dot_col     = dot_col_q;
    assign frame_start = frame_start_q;
    assign wr_ready    = ~pending_q;

endmodule
